// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
//
// Purpose : Shared constants for the board-button conditioner: button index
//           map, per-channel FSM state encodings, default debounce / repeat
//           cycle counts and a helper that sizes the per-channel counters.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

    // Number of board buttons and their bit positions on the button bus.
    localparam int NUM_BTN   = 4;
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_START = 2;
    localparam int BTN_FIRE  = 3;

    // Per-channel debounce FSM encodings.
    localparam logic [1:0] ST_IDLE      = 2'd0;  // stable released
    localparam logic [1:0] ST_PRESS_CHK = 2'd1;  // qualifying a press
    localparam logic [1:0] ST_HELD      = 2'd2;  // stable pressed
    localparam logic [1:0] ST_REL_CHK   = 2'd3;  // qualifying a release

    // Default timing, in clk cycles.
    localparam int DEF_DEBOUNCE_CYC  = 250000;
    localparam int DEF_REPEAT_DELAY  = 12500000;
    localparam int DEF_REPEAT_PERIOD = 2500000;

    // Auto-repeat is enabled on the fire button only by default.
    localparam logic [NUM_BTN-1:0] DEF_REPEAT_MASK = 4'b1000;

    // Counter width shared by the debounce and repeat counters: $clog2 of
    // the largest timing parameter. Counters only ever reach (value - 1),
    // so this width always holds the terminal count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        if (m < 2) begin
            return 1;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/input_conditioner_btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
//
// Purpose : One button channel: 2-flop synchronizer with inversion to
//           active-high, 4-state debounce FSM with saturating counter,
//           optional auto-repeat generator. All outputs are registered.
// Ports   : clk      - system clock
//           srst     - synchronous active-high reset
//           btn_raw  - raw button, active-low, asynchronous to clk
//           level    - debounced level, active-high
//           press    - one-cycle pulse on accepted press
//           rel      - one-cycle pulse on accepted release
//           rpt      - one-cycle auto-repeat pulse (0 when REPEAT_EN = 0)
// -----------------------------------------------------------------------------
module btn_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Synchronizer. Reset value 1 means "released" on the raw active-low
    // line, so a button held through reset is seen as a fresh press.
    // ------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       sample;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], btn_raw};
        end
    end

    assign sample = ~sync_reg[1];

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] deb_reg, deb_next;
    logic             level_reg, level_next;
    logic             press_reg, press_next;
    logic             rel_reg, rel_next;

    always_comb begin
        state_next = state_reg;
        deb_next   = deb_reg;
        level_next = level_reg;
        press_next = 1'b0;
        rel_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sample) begin
                    state_next = ST_PRESS_CHK;
                    deb_next   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!sample) begin
                    // Bounced back before qualifying: silently abandon.
                    state_next = ST_IDLE;
                    deb_next   = '0;
                end else if (deb_reg == DEB_LAST) begin
                    state_next = ST_HELD;
                    deb_next   = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else if (deb_reg != CNT_MAX) begin
                    deb_next = deb_reg + 1'b1;
                end
            end
            ST_HELD: begin
                if (!sample) begin
                    state_next = ST_REL_CHK;
                    deb_next   = '0;
                end
            end
            ST_REL_CHK: begin
                if (sample) begin
                    state_next = ST_HELD;
                    deb_next   = '0;
                end else if (deb_reg == DEB_LAST) begin
                    state_next = ST_IDLE;
                    deb_next   = '0;
                    level_next = 1'b0;
                    rel_next   = 1'b1;
                end else if (deb_reg != CNT_MAX) begin
                    deb_next = deb_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                deb_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
            deb_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            rel_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            deb_reg   <= deb_next;
            level_reg <= level_next;
            press_reg <= press_next;
            rel_reg   <= rel_next;
        end
    end

    assign level = level_reg;
    assign press = press_reg;
    assign rel   = rel_reg;

    // ------------------------------------------------------------------
    // Auto-repeat. The counter reloads after each pulse; first_reg selects
    // the initial delay versus the steady period. Counting happens only
    // while HELD with the button still down, so the edge that moves the
    // FSM into REL_CHK already produces no pulse.
    // ------------------------------------------------------------------
    if (REPEAT_EN) begin : g_repeat
        localparam logic [CNT_W-1:0] RPT_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
        localparam logic [CNT_W-1:0] RPT_NEXT_LAST  = CNT_W'(REPEAT_PERIOD - 1);

        logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
        logic [CNT_W-1:0] rpt_last;
        logic             first_reg, first_next;
        logic             rpt_reg, rpt_next;

        assign rpt_last = first_reg ? RPT_FIRST_LAST : RPT_NEXT_LAST;

        always_comb begin
            rpt_cnt_next = rpt_cnt_reg;
            first_next   = first_reg;
            rpt_next     = 1'b0;
            if (press_next) begin
                // Re-arm on the press edge; press and repeat never coincide.
                rpt_cnt_next = '0;
                first_next   = 1'b1;
            end else if (state_reg == ST_HELD && sample) begin
                if (rpt_cnt_reg == rpt_last) begin
                    rpt_next     = 1'b1;
                    rpt_cnt_next = '0;
                    first_next   = 1'b0;
                end else if (rpt_cnt_reg != CNT_MAX) begin
                    rpt_cnt_next = rpt_cnt_reg + 1'b1;
                end
            end else begin
                rpt_cnt_next = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (srst) begin
                rpt_cnt_reg <= '0;
                first_reg   <= 1'b1;
                rpt_reg     <= 1'b0;
            end else begin
                rpt_cnt_reg <= rpt_cnt_next;
                first_reg   <= first_next;
                rpt_reg     <= rpt_next;
            end
        end

        assign rpt = rpt_reg;
    end else begin : g_no_repeat
        assign rpt = 1'b0;
    end

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Purpose : Conditions the four raw active-low board buttons into clean,
//           debounced active-high levels plus press / release / auto-repeat
//           pulses. One independent btn_channel per button.
// Ports   : i_Clk        - system clock (single domain)
//           i_Rst        - synchronous active-high reset
//           i_Btn[3:0]   - raw buttons, active-low, asynchronous
//                          (0 left, 1 right, 2 start/stop, 3 fire)
//           o_BtnLevel   - debounced level, 1 = held
//           o_BtnPress   - one-cycle pulse per accepted press
//           o_BtnRelease - one-cycle pulse per accepted release
//           o_BtnRepeat  - one-cycle auto-repeat pulse on REPEAT_MASK bits
// -----------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int                 DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int                 REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int                 REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK   = DEF_REPEAT_MASK
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [NUM_BTN-1:0] i_Btn,
    output logic [NUM_BTN-1:0] o_BtnLevel,
    output logic [NUM_BTN-1:0] o_BtnPress,
    output logic [NUM_BTN-1:0] o_BtnRelease,
    output logic [NUM_BTN-1:0] o_BtnRepeat
);

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_MASK[gi])
        ) u_btn_channel (
            .clk     (i_Clk),
            .srst    (i_Rst),
            .btn_raw (i_Btn[gi]),
            .level   (o_BtnLevel[gi]),
            .press   (o_BtnPress[gi]),
            .rel     (o_BtnRelease[gi]),
            .rpt     (o_BtnRepeat[gi])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed bench for input_conditioner with DEBOUNCE_CYC=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Inputs change after the falling edge; outputs are sampled
// 1 time unit after the rising edge. A row/step index k refers to the rising
// edge that samples the inputs driven for that row, so a clean edge first
// sampled at k shows its pulse at k+6.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int D_CYC  = 4;
    localparam int R_DLY  = 10;
    localparam int R_PER  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] level, press, rel, rpt;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYC  (D_CYC),
        .REPEAT_DELAY  (R_DLY),
        .REPEAT_PERIOD (R_PER),
        .REPEAT_MASK   (4'b1000)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Btn        (btn),
        .o_BtnLevel   (level),
        .o_BtnPress   (press),
        .o_BtnRelease (rel),
        .o_BtnRepeat  (rpt)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] btn;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rls;
        logic [3:0] rpt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input int n, input logic r, input logic [3:0] b,
                       input logic [3:0] l, input logic [3:0] p,
                       input logic [3:0] rl, input logic [3:0] rp);
        vec_t v;
        v.rst = r; v.btn = b; v.lvl = l; v.prs = p; v.rls = rl; v.rpt = rp;
        for (int i = 0; i < n; i++) begin
            vecs.push_back(v);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] b);
        @(negedge clk);
        rst = r;
        btn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input string tag, input int idx,
                       input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s %s[%0d]: got %b expected %b", name, tag, idx, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx,
                           input logic [3:0] el, input logic [3:0] ep,
                           input logic [3:0] er, input logic [3:0] erp);
        $display("%s[%0d] rst=%b btn=%b -> level=%b press=%b release=%b repeat=%b",
                 tag, idx, rst, btn, level, press, rel, rpt);
        chk("level",   tag, idx, level, el);
        chk("press",   tag, idx, press, ep);
        chk("release", tag, idx, rel,   er);
        chk("repeat",  tag, idx, rpt,   erp);
    endtask

    initial begin
        logic [3:0] b;
        logic [3:0] el, ep, er, erp;

        rst = 1'b1;
        btn = 4'hF;

        // ---------------- vector table ----------------
        // reset, then idle
        add(2, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 0-1
        add(2, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 2-3
        // glitch on start/stop: 3 low samples, no pulses
        add(3, 1'b0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 4-6
        add(6, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 7-12
        // clean fire press, first low sample at 13 -> press at 19
        add(6, 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 13-18
        add(1, 1'b0, 4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0000);   // 19
        add(3, 1'b0, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000);   // 20-22
        // clean fire release, first high sample at 23 -> release at 29
        add(6, 1'b0, 4'b1111, 4'b1000, 4'b0000, 4'b0000, 4'b0000);   // 23-28
        add(1, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0000);   // 29
        add(3, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 30-32
        // bouncing right press: low 2, high 1, then low from 36 -> press at 42
        add(2, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 33-34
        add(1, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 35
        add(6, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 36-41
        add(1, 1'b0, 4'b1101, 4'b0010, 4'b0010, 4'b0000, 4'b0000);   // 42
        add(2, 1'b0, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0000);   // 43-44
        // right release at 45 -> release at 51
        add(6, 1'b0, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 4'b0000);   // 45-50
        add(1, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0000);   // 51
        add(2, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);   // 52-53

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].btn);
            chk_all("vec", i, vecs[i].lvl, vecs[i].prs, vecs[i].rls, vecs[i].rpt);
        end

        // ---------------- fire + left held: auto-repeat, then fire release ----------------
        // Press at k=6 on both; fire repeats at 16, 19, 22, 25, 28. Fire goes
        // high at k=28, REL_CHK from k=30, release pulse at k=34.
        for (int k = 0; k <= 40; k++) begin
            b = (k < 28) ? 4'b0110 : 4'b1110;
            step(1'b0, b);
            ep  = (k == 6) ? 4'b1001 : 4'b0000;
            el  = {(k >= 6 && k < 34), 2'b00, (k >= 6)};
            er  = (k == 34) ? 4'b1000 : 4'b0000;
            erp = {(k >= 16 && k <= 28 && ((k - 16) % 3) == 0), 3'b000};
            chk_all("rep", k, el, ep, er, erp);
        end
        // release left
        for (int k = 0; k <= 9; k++) begin
            step(1'b0, 4'b1111);
            el = {3'b000, (k < 6)};
            er = (k == 6) ? 4'b0001 : 4'b0000;
            chk_all("rel0", k, el, 4'b0000, er, 4'b0000);
        end

        // ---------------- reset in the middle of a hold ----------------
        // Fire pressed (accepted at k=6); start/stop begins a press at k=5
        // that reset cuts short.
        for (int k = 0; k <= 7; k++) begin
            b = (k >= 5) ? 4'b0011 : 4'b0111;
            step(1'b0, b);
            el = (k >= 6) ? 4'b1000 : 4'b0000;
            ep = (k == 6) ? 4'b1000 : 4'b0000;
            chk_all("pre", k, el, ep, 4'b0000, 4'b0000);
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 4'b0011);
            chk_all("rst", k, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        // fire still held, start/stop released: one fire press 6 later
        for (int k = 0; k <= 9; k++) begin
            step(1'b0, 4'b0111);
            el = (k >= 6) ? 4'b1000 : 4'b0000;
            ep = (k == 6) ? 4'b1000 : 4'b0000;
            chk_all("post", k, el, ep, 4'b0000, 4'b0000);
        end
        for (int k = 0; k <= 8; k++) begin
            step(1'b0, 4'b1111);
            el = (k < 6) ? 4'b1000 : 4'b0000;
            er = (k == 6) ? 4'b1000 : 4'b0000;
            chk_all("end", k, el, 4'b0000, er, 4'b0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYC, 250000: cycles a synchronized level must stay stable before it is accepted; legal range >= 2.
REQ-002 Parameter REPEAT_DELAY, 12500000: cycles from an accepted press to the first auto-repeat pulse; legal range >= 1.
REQ-003 Parameter REPEAT_PERIOD, 2500000: cycles between successive auto-repeat pulses; legal range >= 1.
REQ-004 Parameter REPEAT_MASK, 4'b1000: per-channel auto-repeat enable (fire button only by default).
REQ-005 i_Clk  input  1  system clock; one clock domain only.
REQ-006 i_Rst  input  1  reset, synchronous, active-high.
REQ-007 i_Btn  input  4  raw board buttons, active-low (0 = pressed), asynchronous to i_Clk; bit 0 left, 1 right, 2 start/stop, 3 fire.
REQ-008 o_BtnLevel  output  4  debounced level, active-high (1 = held).
REQ-009 o_BtnPress  output  4  one-cycle pulse on each accepted press.
REQ-010 o_BtnRelease  output  4  one-cycle pulse on each accepted release.
REQ-011 o_BtnRepeat  output  4  one-cycle auto-repeat pulse; only on REPEAT_MASK channels.

Function
REQ-012 Each i_Btn bit SHALL pass through a 2-flop synchronizer and be inverted to active-high before any other logic.
REQ-013 Each channel SHALL run an independent 4-state FSM: IDLE (released), PRESS_CHK, HELD, REL_CHK.
REQ-014 IDLE -> PRESS_CHK when the synchronized sample is 1; HELD -> REL_CHK when the synchronized sample is 0; the debounce counter is cleared on entry.
REQ-015 In PRESS_CHK or REL_CHK, if the sample returns to the old level before the counter reaches DEBOUNCE_CYC-1, the FSM SHALL return to the previous stable state and clear the counter, with no output pulse.
REQ-016 When the counter reaches DEBOUNCE_CYC-1 with the new level still present, the FSM SHALL enter HELD or IDLE, update o_BtnLevel, and pulse o_BtnPress or o_BtnRelease for exactly one cycle.
REQ-017 Latency: for a clean edge, the press or release pulse and the o_BtnLevel change SHALL appear exactly DEBOUNCE_CYC+2 cycles after the first clock edge that samples the new raw level.
REQ-018 All outputs SHALL be registered; no combinational path from i_Btn to any output.
REQ-019 Repeat counter (per masked channel): cleared on the press pulse, counts only in HELD, first o_BtnRepeat pulse at press+REPEAT_DELAY, then every REPEAT_PERIOD cycles while in HELD.
REQ-020 o_BtnRepeat SHALL never coincide with o_BtnPress on the same channel; the repeat counter is cleared on leaving HELD, and no repeat pulse is issued in REL_CHK.
REQ-021 Channels SHALL be independent; simultaneous pulses on several channels in one cycle are legal.
REQ-022 Counter widths SHALL be $clog2 of the largest parameter value; counters saturate and never wrap.

Reset
REQ-023 While i_Rst=1 at a clock edge: synchronizer flops <= 1 (released), FSMs <= IDLE, counters <= 0, all outputs <= 0 on the next cycle.
REQ-024 A button held through reset deassertion SHALL give one press pulse DEBOUNCE_CYC+2 cycles after the first post-reset sample; a press or release cut short by reset SHALL give no pulse.

Structure
REQ-025 The shared parameter package SHALL hold the button index constants (BTN_LEFT=0, BTN_RIGHT=1, BTN_START=2, BTN_FIRE=3), the FSM state encodings, and the default debounce and repeat cycle counts.
REQ-026 A single-channel sub-module btn_channel (synchronizer, FSM, debounce counter, repeat counter, REPEAT_EN parameter) SHALL be instantiated 4 times by a generate loop.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Clean press: i_Btn[3] held 0 for 30 cycles -> one o_BtnPress[3] pulse 6 cycles after the first low sample, o_BtnLevel[3]=1 from then.
REQ-028 Bounce: i_Btn[1] low 2, high 1, then held low -> exactly one o_BtnPress[1], 6 cycles after the final falling sample.
REQ-029 Glitch: i_Btn[2] low 3 cycles, then high -> no pulses, o_BtnLevel[2] stays 0.
REQ-030 Repeat: hold i_Btn[3] and i_Btn[0] together -> o_BtnRepeat[3] at press+10, +13, +16 and so on; o_BtnRepeat[0] stays 0; both press pulses occur in the same cycle.
REQ-031 Release: i_Btn[3] goes high after the repeat pulses -> o_BtnRelease[3] 6 cycles later, repeats stop the cycle REL_CHK is entered.
REQ-032 Reset mid-hold: i_Rst=1 for 2 cycles while i_Btn[3]=0 -> all outputs 0 during reset; after release with the button still low, o_BtnPress[3] 6 cycles later.
